// File: rtl/pi_so_frame_tx.sv
// pi_so_frame_tx -- parallel-in serial-out frame transmitter.
//
// Takes a byte through a load/ready handshake and sends it as one start bit
// (0), eight data bits MSB-first and one stop bit (1). Each bit is held for
// BIT_CYCLES clocks. SRControl strobes during the last clock of every bit
// period, so a downstream serial-in register samples each bit exactly once.
//
// Optional feature: define PI_SO_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
//
// Parameters:
//   BIT_CYCLES  clocks per serial bit, 1..256
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   PI[7:0]    byte to send, sampled only when a load is accepted
//   load       request to send PI (honoured only while idle)
//   ready      high while a load will be accepted
//   SO         serial data out, idles high
//   SRControl  receiver shift strobe, last clock of each bit period
//   tx_done    one-clock pulse in the first idle cycle after a frame
//
// All outputs come straight from flops; their next values are decoded from
// the next-state signals so they line up with the state they describe.

module pi_so_frame_tx #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] PI,
    input  logic       load,
    output logic       ready,
    output logic       SO,
    output logic       SRControl,
    output logic       tx_done
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

`ifdef PI_SO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          so_d, ready_d, src_d, done_d;
    logic          bit_end;
`ifdef PI_SO_PARITY_EN
    logic          par_q, par_d;
`endif

    assign bit_end = (cnt_q == LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
`ifdef PI_SO_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == IDLE) begin
            if (load) begin
                state_d = START;
                sr_d    = PI;
                cnt_d   = '0;
                bit_d   = '0;
`ifdef PI_SO_PARITY_EN
                // Parity taken at capture; the shift register is consumed later.
                par_d   = ^PI;
`endif
            end
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
                case (state_q)
                    START: state_d = DATA;
                    DATA: begin
                        sr_d = {sr_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
`ifdef PI_SO_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
`ifdef PI_SO_PARITY_EN
                    PARITY: state_d = STOP;
`endif
                    STOP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output decode from next state, registered below
    always_comb begin
        so_d    = 1'b1;
        ready_d = (state_d == IDLE);
        src_d   = (state_d != IDLE) && (cnt_d == LAST);
        case (state_d)
            START:  so_d = 1'b0;
            DATA:   so_d = sr_d[7];
`ifdef PI_SO_PARITY_EN
            PARITY: so_d = par_d;
`endif
            default: so_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            SO        <= 1'b1;
            ready     <= 1'b1;
            SRControl <= 1'b0;
            tx_done   <= 1'b0;
`ifdef PI_SO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            SO        <= so_d;
            ready     <= ready_d;
            SRControl <= src_d;
            tx_done   <= done_d;
`ifdef PI_SO_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_pi_so_frame_tx.sv
// Testbench for pi_so_frame_tx: one instance with BIT_CYCLES=1 and one with
// BIT_CYCLES=4 share a clock and reset. Frames are described by a vector
// table and checked cycle by cycle, with a loopback receiver rebuilding the
// byte from SO on SRControl strobes.

module tb_pi_so_frame_tx;

`ifdef PI_SO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pi1, pi4;
    logic       load1, load4;
    logic       rdy1, so1, src1, done1;
    logic       rdy4, so4, src4, done4;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    logic rdy_m, so_m, src_m, done_m;

    always #5 clk = ~clk;

    pi_so_frame_tx #(.BIT_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst), .PI(pi1), .load(load1),
        .ready(rdy1), .SO(so1), .SRControl(src1), .tx_done(done1)
    );

    pi_so_frame_tx #(.BIT_CYCLES(4)) u_d4 (
        .clk(clk), .rst(rst), .PI(pi4), .load(load4),
        .ready(rdy4), .SO(so4), .SRControl(src4), .tx_done(done4)
    );

    always_comb begin
        rdy_m  = (cur == 1) ? rdy4  : rdy1;
        so_m   = (cur == 1) ? so4   : so1;
        src_m  = (cur == 1) ? src4  : src1;
        done_m = (cur == 1) ? done4 : done1;
    end

    typedef struct {
        int         sel;   // 0: BIT_CYCLES=1, 1: BIT_CYCLES=4
        logic [7:0] pi;
        logic       par;   // even parity of pi
        int         inj;   // cycle at which a stray load of 8'hFF is pulsed, -1 none
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] pi, input logic par, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return pi[8-p];
        if (p == 9 && NB == 11) return par;
        return 1'b1;
    endfunction

    task automatic set_load(input int sel, input logic l, input logic [7:0] d);
        if (sel == 1) begin load4 = l; pi4 = d; end
        else          begin load1 = l; pi1 = d; end
    endtask

    // Called at a negedge with the selected DUT idle.
    task automatic run_frame(input int sel, input logic [7:0] pi, input logic par, input int inj);
        int bc;
        int len;
        int nrx;
        logic [10:0] rx;
        bc  = (sel == 1) ? 4 : 1;
        len = NB * bc;
        nrx = 0;
        rx  = '0;
        cur = sel;
        set_load(sel, 1'b1, pi);
        @(posedge clk);
        #1 set_load(sel, 1'b0, ~pi);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            chk("so", {7'b0, so_m}, {7'b0, frame_bit(pi, par, j / bc)});
            chk("srcontrol", {7'b0, src_m}, {7'b0, (j % bc) == bc - 1});
            chk("ready_busy", {7'b0, rdy_m}, 8'h00);
            chk("done_busy", {7'b0, done_m}, 8'h00);
            if (src_m) begin
                rx = {rx[9:0], so_m};
                nrx++;
            end
            if (inj >= 0 && j == inj)     set_load(sel, 1'b1, 8'hFF);
            if (inj >= 0 && j == inj + 1) set_load(sel, 1'b0, 8'hFF);
        end
        @(negedge clk);
        chk("done_pulse", {7'b0, done_m}, 8'h01);
        chk("ready_back", {7'b0, rdy_m}, 8'h01);
        chk("so_idle", {7'b0, so_m}, 8'h01);
        chk("src_idle", {7'b0, src_m}, 8'h00);
        @(negedge clk);
        chk("done_once", {7'b0, done_m}, 8'h00);
        chk("still_idle", {7'b0, rdy_m}, 8'h01);
        chk("rx_count", nrx[7:0], NB[7:0]);
        chk("rx_start", {7'b0, rx[NB-1]}, 8'h00);
        chk("rx_byte", rx[NB-2 -: 8], pi);
    endtask

    initial begin
        vecs[0] = '{sel: 0, pi: 8'hA5, par: 1'b0, inj: -1};
        vecs[1] = '{sel: 0, pi: 8'h07, par: 1'b1, inj: -1};
        vecs[2] = '{sel: 1, pi: 8'h3C, par: 1'b0, inj: -1};
        vecs[3] = '{sel: 0, pi: 8'h00, par: 1'b0, inj: 3};
        vecs[4] = '{sel: 1, pi: 8'h00, par: 1'b0, inj: 10};
        vecs[5] = '{sel: 0, pi: 8'h01, par: 1'b1, inj: -1};
        vecs[6] = '{sel: 1, pi: 8'hE6, par: 1'b1, inj: -1};

        // Reset held two clocks with load asserted
        rst = 1'b1;
        load1 = 1'b1; pi1 = 8'h55;
        load4 = 1'b1; pi4 = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_so1", {7'b0, so1}, 8'h01);
        chk("rst_ready1", {7'b0, rdy1}, 8'h01);
        chk("rst_src1", {7'b0, src1}, 8'h00);
        chk("rst_done1", {7'b0, done1}, 8'h00);
        chk("rst_so4", {7'b0, so4}, 8'h01);
        chk("rst_ready4", {7'b0, rdy4}, 8'h01);
        rst = 1'b0;
        load1 = 1'b0;
        load4 = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {7'b0, rdy1}, 8'h01);
        chk("post_rst_so", {7'b0, so1}, 8'h01);

        for (int v = 0; v < 7; v++)
            run_frame(vecs[v].sel, vecs[v].pi, vecs[v].par, vecs[v].inj);

        // Reset during data bit 3 of 8'h81 (BIT_CYCLES=4: cycles 16..19)
        cur = 1;
        set_load(1, 1'b1, 8'h81);
        @(posedge clk);
        #1 set_load(1, 1'b0, 8'h81);
        for (int j = 0; j <= 17; j++) @(negedge clk);
        chk("pre_abort_so", {7'b0, so4}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_so", {7'b0, so4}, 8'h01);
        chk("abort_ready", {7'b0, rdy4}, 8'h01);
        chk("abort_src", {7'b0, src4}, 8'h00);
        chk("abort_done", {7'b0, done4}, 8'h00);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("abort_no_done", {7'b0, done4}, 8'h00);
            chk("abort_idle", {7'b0, rdy4}, 8'h01);
        end
        run_frame(1, 8'h81, 1'b0, -1);

        // load held high: back-to-back frames, one every NB+1 clocks
        cur = 0;
        set_load(0, 1'b1, 8'hA5);
        @(posedge clk);
        for (int j = 0; j <= 2 * NB + 2; j++) begin
            @(negedge clk);
            chk("b2b_done", {7'b0, done1}, {7'b0, (j == NB) || (j == 2 * NB + 1)});
            chk("b2b_ready", {7'b0, rdy1}, {7'b0, (j == NB) || (j >= 2 * NB + 1)});
            if (j == NB + 1) set_load(0, 1'b0, 8'hA5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
